div_pow2: RTL and testbench



---
 rtl/div_pow2_pkg.sv | 17 +
 rtl/div_pow2_core.sv | 43 ++++
 rtl/div_pow2.sv | 51 +++++
 tb/tb_div_pow2.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/div_pow2_pkg.sv
// -----------------------------------------------------------------------------
// div_pow2_pkg
// Shared types and constants for the signed power-of-two divider.
//   data_t    : signed 8-bit dividend / quotient
//   shamt_t   : unsigned 8-bit shift amount (divisor is 2^shamt)
//   DATA_W    : datapath width
//   MAX_SHIFT : largest shift that can leave a nonzero quotient
// -----------------------------------------------------------------------------
package div_pow2_pkg;

    localparam int DATA_W    = 8;
    localparam int MAX_SHIFT = 7;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic        [DATA_W-1:0] shamt_t;

endpackage

// File: rtl/div_pow2_core.sv
// -----------------------------------------------------------------------------
// div_pow2_core
// Combinational signed divide by 2^y, truncating toward zero.
// Ports:
//   x (in,  8) signed dividend
//   y (in,  8) unsigned shift amount
//   q (out, 8) signed quotient, rounded toward zero
// -----------------------------------------------------------------------------
module div_pow2_core
    import div_pow2_pkg::*;
(
    input  data_t  x,
    input  shamt_t y,
    output data_t  q
);

    logic [2:0] shamt;
    logic       bigShift;
    data_t      shifted;
    data_t      dropMask;
    logic       sticky;

    // Only shifts 0..7 can leave anything of an 8-bit value; any bit set in
    // the upper part of y means the quotient is zero for every dividend.
    assign shamt    = y[2:0];
    assign bigShift = |y[DATA_W-1:MAX_SHIFT-4];

    // The arithmetic shift rounds toward negative infinity. For a negative
    // dividend that lost any 1 bits, add one to pull the result back toward
    // zero. dropMask selects exactly the bits the shift discards.
    always_comb begin
        shifted  = x >>> shamt;
        dropMask = data_t'((9'd1 << shamt) - 9'd1);
        sticky   = |(x & dropMask);
        q        = shifted;
        if (bigShift) begin
            q = '0;
        end else if (x[DATA_W-1] && sticky) begin
            q = shifted + data_t'(1);
        end
    end

endmodule

// File: rtl/div_pow2.sv
// -----------------------------------------------------------------------------
// div_pow2
// Signed power-of-two divider: x_i / 2^y_i truncated toward zero, as in C.
// Ports:
//   clk_i    (in,  1) datapath clock, rising edge
//   rst_i    (in,  1) asynchronous active-high reset
//   x_i      (in,  8) signed dividend
//   y_i      (in,  8) unsigned shift amount
//   output__ (out, 8) quotient; combinational by default
//   result_q (out, 8) registered quotient, one cycle latency
// Configuration macro: E_COUNTER_REG_OUT_EN
//   undefined : output__ is the combinational quotient
//   defined   : output__ is driven from result_q
// -----------------------------------------------------------------------------
module div_pow2
    import div_pow2_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  data_t x_i,
    input  shamt_t y_i,
    output data_t output__,
    output data_t result_q
);

    data_t quot;

    div_pow2_core u_core (
        .x (x_i),
        .y (y_i),
        .q (quot)
    );

    // Capture the quotient every cycle; reset clears it without a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
        end else begin
            result_q <= quot;
        end
    end

    // Choose whether the primary output sees the quotient immediately or
    // after the register.
`ifdef E_COUNTER_REG_OUT_EN
    assign output__ = result_q;
`else
    assign output__ = quot;
`endif

endmodule

// File: tb/tb_div_pow2.sv
// -----------------------------------------------------------------------------
// tb_div_pow2
// Self-checking bench for div_pow2. The reference quotient comes from plain
// integer division, which truncates toward zero.
// -----------------------------------------------------------------------------
module tb_div_pow2;
    import div_pow2_pkg::*;

    logic   clk_i = 1'b0;
    logic   rst_i = 1'b0;
    data_t  x_i   = '0;
    shamt_t y_i   = '0;
    data_t  output__;
    data_t  result_q;

    int errors = 0;
    int checks = 0;

    div_pow2 dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .x_i      (x_i),
        .y_i      (y_i),
        .output__ (output__),
        .result_q (result_q)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Reference: divide by 2^y with integer arithmetic; huge divisors give 0.
    function automatic data_t refQuot(input data_t xv, input shamt_t yv);
        int num;
        int den;
        if (yv > 8'd7) begin
            return '0;
        end
        num = int'(xv);
        den = 1 << yv;
        return data_t'(num / den);
    endfunction

    // Drive a new operand pair just after a falling edge.
    task automatic applyStimulus(input data_t xv, input shamt_t yv);
        @(negedge clk_i);
        x_i = xv;
        y_i = yv;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input data_t obs, input data_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply an operand, check the combinational path in the default build,
    // then check both outputs after the capturing edge.
    task automatic runOperand(input string tag, input data_t xv, input shamt_t yv);
        data_t exp;
        exp = refQuot(xv, yv);
        applyStimulus(xv, yv);
`ifndef E_COUNTER_REG_OUT_EN
        #1;
        checkOutput({tag, "_comb"}, output__, exp);
`endif
        @(posedge clk_i);
        #1;
        checkOutput({tag, "_reg"}, result_q, exp);
        checkOutput({tag, "_out"}, output__, exp);
    endtask

    data_t  spotX [8] = '{-8'sd7, 8'sd7, -8'sd1, -8'sd128, -8'sd8, -8'sd128, -8'sd128, 8'sd127};
    shamt_t spotY [8] = '{8'd1, 8'd1, 8'd3, 8'd7, 8'd2, 8'd0, 8'd8, 8'd9};
    data_t  spotQ [8] = '{-8'sd3, 8'sd3, 8'sd0, -8'sd1, -8'sd2, -8'sd128, 8'sd0, 8'sd0};

    initial begin
        data_t  rx;
        shamt_t ry;

        $display("[TB] div_pow2 bench start");

        // Reset asserts without a clock edge and clears the register.
        #1 rst_i = 1'b1;
        #1;
        checkOutput("reset_immediate", result_q, data_t'(0));
        @(posedge clk_i);
        #1;
        checkOutput("reset_held", result_q, data_t'(0));
`ifdef E_COUNTER_REG_OUT_EN
        checkOutput("reset_out", output__, data_t'(0));
`endif
        @(negedge clk_i);
        rst_i = 1'b0;

        // Hand-computed spot checks, exact divisions and large shifts.
        for (int i = 0; i < 8; i++) begin
            runOperand($sformatf("spot%0d", i), spotX[i], spotY[i]);
            checkOutput($sformatf("spot%0d_const", i), result_q, spotQ[i]);
        end
        runOperand("big255_neg", -8'sd128, 8'd255);
        runOperand("big255_pos", 8'sd127, 8'd255);
        runOperand("big8_pos", 8'sd127, 8'd8);

        // Exhaustive sweep of every dividend and every meaningful shift,
        // one operand per cycle.
        for (int yy = 0; yy < 8; yy++) begin
            for (int xx = -128; xx < 128; xx++) begin
                runOperand("sweep", data_t'(xx), shamt_t'(yy));
            end
        end

        // Random operands, half with small shifts and half with any shift.
        for (int i = 0; i < 300; i++) begin
            rx = data_t'($urandom);
            ry = (i % 2 == 0) ? shamt_t'($urandom_range(0, 7)) : shamt_t'($urandom);
            runOperand("random", rx, ry);
        end

        // Mid-cycle reset with the register holding 5, then recovery.
        runOperand("preload5", 8'sd5, 8'd0);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("midcycle_reset", result_q, data_t'(0));
`ifndef E_COUNTER_REG_OUT_EN
        checkOutput("reset_no_comb_effect", output__, data_t'(5));
`else
        checkOutput("reset_out_cleared", output__, data_t'(0));
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        runOperand("after_reset", -8'sd9, 8'd2);
        checkOutput("after_reset_const", result_q, -8'sd2);

`ifdef E_COUNTER_REG_OUT_EN
        // Registered output holds the previous quotient until the edge.
        applyStimulus(8'sd100, 8'd3);
        #1;
        checkOutput("regout_hold", output__, -8'sd2);
        @(posedge clk_i);
        #1;
        checkOutput("regout_update", output__, 8'sd12);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
